// File: rtl/urv_pipe_ctrl.sv
// Pipeline control for uRV cores: per-stage stall/kill, branch shadow tracking,
// drain/halt sequencing for debug entry and saturating stall/branch counters.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_RUN    | normal operation, fetch enabled
//   ST_DRAIN  | fetch stopped, waiting for the pipe and branch shadow to empty
//   ST_HALTED | pipe empty, core halted until resume_i
module urv_pipe_ctrl #(
  parameter int g_num_stages    = 4,
  parameter int g_bra_stage     = 2,
  parameter int g_drain_timeout = 64,
  parameter int g_perf_width    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_num_stages-1:0] stall_req_i,
  input  logic [g_num_stages-1:0] stage_valid_i,
  input  logic                    bra_i,
  input  logic                    halt_req_i,
  input  logic                    resume_i,
  input  logic                    perf_clr_i,
  output logic [g_num_stages-1:0] stall_o,
  output logic [g_num_stages-1:0] kill_o,
  output logic                    fetch_en_o,
  output logic                    halted_o,
  output logic                    drain_err_o,
  output logic [g_perf_width-1:0] stall_cnt_o,
  output logic [g_perf_width-1:0] bra_cnt_o
);

  localparam int N  = g_num_stages;
  localparam int B  = g_bra_stage;
  localparam int W  = g_perf_width;
  localparam int TW = $clog2(g_drain_timeout + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(g_drain_timeout - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic [B-1:0]    sh_q;
  logic [TW-1:0]   tmr_q;
  logic            tmr_tc;
  logic            drain_err_q;
  logic            pipe_empty;
  logic            stall_inc;
  logic            bra_acc;
  logic [W-1:0]    stall_cnt_q;
  logic [W-1:0]    bra_cnt_q;

  // Any request downstream stalls a stage; stages below B ignore their own request.
  always_comb begin
    logic above;
    above   = 1'b0;
    stall_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      stall_o[i] = above | (stall_req_i[i] & (i >= B));
      above      = above | stall_req_i[i];
    end
  end

  // Stage i is killed while any branch of age <= i is still in the shadow.
  always_comb begin
    logic shadow_any;
    shadow_any = 1'b0;
    kill_o     = '0;
    for (int i = 1; i <= B; i++) begin
      shadow_any = shadow_any | sh_q[i-1];
      kill_o[i]  = bra_i | shadow_any;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else if (!stall_o[B]) begin
      sh_q <= B'({sh_q, bra_i});
    end
  end

  assign pipe_empty = (stage_valid_i == '0) && (sh_q == '0);
  assign tmr_tc     = (tmr_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req_i) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty || tmr_tc) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (resume_i && !halt_req_i) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    fetch_en_o = (state_q == ST_RUN);
    halted_o   = (state_q == ST_HALTED);
  end

  // An empty pipe on the terminal-count cycle still counts as a clean drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_q       <= '0;
      drain_err_q <= 1'b0;
    end else if (state_q == ST_RUN && halt_req_i) begin
      tmr_q       <= TMR_LOAD;
      drain_err_q <= 1'b0;
    end else if (state_q == ST_DRAIN) begin
      if (!pipe_empty && tmr_tc) begin
        drain_err_q <= 1'b1;
      end
      if (!tmr_tc) begin
        tmr_q <= tmr_q - TW'(1);
      end
    end
  end

  assign drain_err_o = drain_err_q;

  assign stall_inc = (state_q == ST_RUN) & stall_o[0];
  assign bra_acc   = bra_i & ~stall_o[B];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      bra_cnt_q   <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_q <= '0;
      bra_cnt_q   <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + W'(1);
      end
      if (bra_acc && (bra_cnt_q != '1)) begin
        bra_cnt_q <= bra_cnt_q + W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign bra_cnt_o   = bra_cnt_q;

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Bench for urv_pipe_ctrl: directed scenarios plus random traffic, all checked
// against a branch-age / drain-cycle reference model.
module tb_urv_pipe_ctrl;

  localparam int N = 4;
  localparam int B = 2;
  localparam int T = 4;
  localparam int W = 4;
  localparam int SAT = (1 << W) - 1;

  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALTED = 2;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] stall_req_i;
  logic [N-1:0] stage_valid_i;
  logic         bra_i;
  logic         halt_req_i;
  logic         resume_i;
  logic         perf_clr_i;
  logic [N-1:0] stall_o;
  logic [N-1:0] kill_o;
  logic         fetch_en_o;
  logic         halted_o;
  logic         drain_err_o;
  logic [W-1:0] stall_cnt_o;
  logic [W-1:0] bra_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  int m_state;
  int m_err;
  int m_drain_n;
  int m_stall_cnt;
  int m_bra_cnt;
  int m_ages[$];

  urv_pipe_ctrl #(
    .g_num_stages   (N),
    .g_bra_stage    (B),
    .g_drain_timeout(T),
    .g_perf_width   (W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_req_i  (stall_req_i),
    .stage_valid_i(stage_valid_i),
    .bra_i        (bra_i),
    .halt_req_i   (halt_req_i),
    .resume_i     (resume_i),
    .perf_clr_i   (perf_clr_i),
    .stall_o      (stall_o),
    .kill_o       (kill_o),
    .fetch_en_o   (fetch_en_o),
    .halted_o     (halted_o),
    .drain_err_o  (drain_err_o),
    .stall_cnt_o  (stall_cnt_o),
    .bra_cnt_o    (bra_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_stall(input logic [N-1:0] req);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (req[j]) s[i] = 1'b1;
      end
      if (req[i] && i >= B) s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [N-1:0] exp_kill();
    logic [N-1:0] k;
    k = '0;
    for (int i = 1; i <= B; i++) begin
      k[i] = bra_i;
      foreach (m_ages[j]) begin
        if (m_ages[j] <= i) k[i] = 1'b1;
      end
    end
    return k;
  endfunction

  task automatic model_reset();
    m_state     = M_RUN;
    m_err       = 0;
    m_drain_n   = 0;
    m_stall_cnt = 0;
    m_bra_cnt   = 0;
    m_ages.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] s;
    bit           empty;
    int           nq[$];
    if (rst_i) begin
      model_reset();
      return;
    end
    s     = exp_stall(stall_req_i);
    empty = (stage_valid_i == '0) && (m_ages.size() == 0);
    if (perf_clr_i) begin
      m_stall_cnt = 0;
      m_bra_cnt   = 0;
    end else begin
      if (m_state == M_RUN && s[0]) m_stall_cnt = (m_stall_cnt < SAT) ? m_stall_cnt + 1 : SAT;
      if (bra_i && !s[B])          m_bra_cnt   = (m_bra_cnt < SAT) ? m_bra_cnt + 1 : SAT;
    end
    if (!s[B]) begin
      foreach (m_ages[j]) begin
        if (m_ages[j] + 1 <= B) nq.push_back(m_ages[j] + 1);
      end
      if (bra_i) nq.push_back(1);
      m_ages = nq;
    end
    case (m_state)
      M_RUN: begin
        if (halt_req_i) begin
          m_state   = M_DRAIN;
          m_err     = 0;
          m_drain_n = 0;
        end
      end
      M_DRAIN: begin
        m_drain_n++;
        if (empty) begin
          m_state = M_HALTED;
        end else if (m_drain_n >= T) begin
          m_state = M_HALTED;
          m_err   = 1;
        end
      end
      default: begin
        if (resume_i && !halt_req_i) m_state = M_RUN;
      end
    endcase
  endtask

  task automatic check_all();
    chk("stall",     32'(stall_o),     32'(exp_stall(stall_req_i)));
    chk("kill",      32'(kill_o),      32'(exp_kill()));
    chk("fetch_en",  32'(fetch_en_o),  32'(m_state == M_RUN));
    chk("halted",    32'(halted_o),    32'(m_state == M_HALTED));
    chk("drain_err", 32'(drain_err_o), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall_cnt));
    chk("bra_cnt",   32'(bra_cnt_o),   32'(m_bra_cnt));
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] valid,
                       input logic bra, input logic halt, input logic res, input logic clr);
    stall_req_i   = req;
    stage_valid_i = valid;
    bra_i         = bra;
    halt_req_i    = halt;
    resume_i      = res;
    perf_clr_i    = clr;
  endtask

  initial begin
    rst_i = 1'b1;
    drive('0, '0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_fetch_en",  32'(fetch_en_o),  32'd1);
    chk("rst_halted",    32'(halted_o),    32'd0);
    chk("rst_drain_err", 32'(drain_err_o), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // stall decode
    drive(4'b0010, '0, 0, 0, 0, 0); #1 chk("stall_0010", 32'(stall_o), 32'b0001); tick();
    drive(4'b0100, '0, 0, 0, 0, 0); #1 chk("stall_0100", 32'(stall_o), 32'b0111); tick();
    drive(4'b1000, '0, 0, 0, 0, 0); #1 chk("stall_1000", 32'(stall_o), 32'b1111); tick();

    // single branch, no stalls
    drive('0, '0, 1, 0, 0, 0); #1 chk("kill_c0", 32'(kill_o[2:1]), 32'b11); tick();
    drive('0, '0, 0, 0, 0, 0); #1 chk("kill_c1", 32'(kill_o[2:1]), 32'b11); tick();
    #1 chk("kill_c2", 32'(kill_o[2:1]), 32'b10); tick();
    #1 chk("kill_c3", 32'(kill_o[2:1]), 32'b00); tick();

    // branch then a 5-cycle downstream stall
    drive('0, '0, 1, 0, 0, 0); tick();
    for (int c = 0; c < 5; c++) begin
      drive(4'b1000, '0, 0, 0, 0, 0);
      #1 chk("kill_hold", 32'(kill_o[2]), 32'd1);
      tick();
    end
    drive('0, '0, 0, 0, 0, 0); #1 chk("kill_rs0", 32'(kill_o[2:1]), 32'b11); tick();
    #1 chk("kill_rs1", 32'(kill_o[2:1]), 32'b10); tick();
    #1 chk("kill_rs2", 32'(kill_o[2:1]), 32'b00); tick();

    // clean drain and resume
    drive('0, 4'b1111, 0, 1, 0, 0); tick();
    drive('0, 4'b0111, 0, 0, 0, 0); #1 chk("drain_fetch_off", 32'(fetch_en_o), 32'd0); tick();
    drive('0, 4'b0011, 0, 0, 0, 0); tick();
    drive('0, 4'b0001, 0, 0, 0, 0); tick();
    drive('0, 4'b0000, 0, 0, 0, 0); #1 chk("drain_not_yet", 32'(halted_o), 32'd0); tick();
    #1 chk("drain_halted", 32'(halted_o), 32'd1);
    chk("drain_clean", 32'(drain_err_o), 32'd0);
    tick();
    drive('0, '0, 0, 0, 1, 0); tick();
    drive('0, '0, 0, 0, 0, 0); #1 chk("resume_fetch", 32'(fetch_en_o), 32'd1); tick();

    // drain timeout with a stuck stage
    drive('0, 4'b0001, 0, 1, 0, 0); tick();
    for (int c = 0; c < T; c++) begin
      drive('0, 4'b0001, 0, 0, 0, 0);
      #1 chk("tmo_wait", 32'(halted_o), 32'd0);
      tick();
    end
    #1 chk("tmo_halted", 32'(halted_o), 32'd1);
    chk("tmo_err", 32'(drain_err_o), 32'd1);
    tick();
    drive('0, 4'b0001, 0, 1, 1, 0); tick();
    drive('0, 4'b0001, 0, 0, 0, 0); #1 chk("halt_wins", 32'(halted_o), 32'd1); tick();
    drive('0, '0, 0, 0, 1, 0); tick();
    drive('0, '0, 0, 0, 0, 0); #1 chk("err_sticky", 32'(drain_err_o), 32'd1); tick();

    // counter saturation and clear
    for (int c = 0; c < 20; c++) begin
      drive(4'b0010, '0, 0, 0, 0, 0);
      tick();
    end
    #1 chk("stall_sat", 32'(stall_cnt_o), 32'd15);
    drive(4'b0010, '0, 0, 0, 0, 1); tick();
    drive('0, '0, 0, 0, 0, 0); #1 chk("perf_clr", 32'(stall_cnt_o), 32'd0); tick();

    // async reset in the middle of a drain
    for (int c = 0; c < 3; c++) begin
      drive(4'b0010, '0, 1, 0, 0, 0);
      tick();
    end
    drive('0, 4'b1111, 0, 1, 0, 0); tick();
    drive('0, 4'b1111, 0, 0, 0, 0); tick();
    #1 chk("pre_rst_drain", 32'(fetch_en_o), 32'd0);
    chk("pre_rst_bra", 32'(bra_cnt_o != '0), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("arst_fetch_en",  32'(fetch_en_o),  32'd1);
    chk("arst_halted",    32'(halted_o),    32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("arst_bra_cnt",   32'(bra_cnt_o),   32'd0);
    model_reset();
    tick();
    rst_i = 1'b0;
    drive('0, '0, 0, 0, 0, 0);
    tick();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 1) == 0) ? 4'b0000 : N'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 4) ? 4'b0000 : N'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 49) == 0));
      if (rst_i) model_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
